// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: opcodes, FSM states,
// ALU/mux select codes and the control word handed from the output decoder to the top.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BRNV  = 6'b010101;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_BRNV   = 4'd9,
        S_ORIEX  = 4'd10,
        S_ORIWB  = 4'd11
    } state_e;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OR    = 2'b11;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

    typedef struct packed {
        logic       pc_en;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       zero_ext;
        logic [1:0] alu_op;
    } ctrl_word_t;

    // States in which the controller stalls on the memory handshake.
    function automatic logic is_wait_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

    function automatic logic is_legal_op(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BRNV, OP_ORI: return 1'b1;
            default:                                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Combinational state -> control word decode; only pc_en and ir_write look at the
// same-cycle datapath/memory flags.
module ctrl_output_decode
    import ctrl_pkg::*;
(
    input  state_e     i_state,
    input  logic       i_zero,
    input  logic       i_v_flag,
    input  logic       i_mem_ready,
    output ctrl_word_t o_cw
);

    always_comb begin
        o_cw = '0;
        case (i_state)
            S_FETCH: begin
                o_cw.mem_read  = 1'b1;
                o_cw.alu_src_b = SRCB_FOUR;
                o_cw.alu_op    = ALU_ADD;
                o_cw.pc_source = PCSRC_ALU;
                o_cw.ir_write  = i_mem_ready;
                o_cw.pc_en     = i_mem_ready;
            end
            S_DECODE: begin
                o_cw.alu_src_b = SRCB_IMM_SH2;
                o_cw.alu_op    = ALU_ADD;
            end
            S_MEMADR: begin
                o_cw.alu_src_a = 1'b1;
                o_cw.alu_src_b = SRCB_IMM;
                o_cw.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                o_cw.iord     = 1'b1;
                o_cw.mem_read = 1'b1;
            end
            S_MEMWB: begin
                o_cw.mem_to_reg = 1'b1;
                o_cw.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                o_cw.iord      = 1'b1;
                o_cw.mem_write = 1'b1;
            end
            S_EXEC: begin
                o_cw.alu_src_a = 1'b1;
                o_cw.alu_src_b = SRCB_B;
                o_cw.alu_op    = ALU_FUNCT;
            end
            S_RWB: begin
                o_cw.reg_dst   = 1'b1;
                o_cw.reg_write = 1'b1;
            end
            S_BEQ, S_BRNV: begin
                o_cw.alu_src_a = 1'b1;
                o_cw.alu_src_b = SRCB_B;
                o_cw.alu_op    = ALU_SUB;
                o_cw.pc_source = PCSRC_ALUOUT;
                // brnv branches when rs-rt did not overflow
                o_cw.pc_en     = (i_state == S_BEQ) ? i_zero : ~i_v_flag;
            end
            S_ORIEX: begin
                o_cw.alu_src_a = 1'b1;
                o_cw.alu_src_b = SRCB_IMM;
                o_cw.zero_ext  = 1'b1;
                o_cw.alu_op    = ALU_OR;
            end
            S_ORIWB: begin
                o_cw.reg_write = 1'b1;
            end
            default: o_cw = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main controller: FSM, memory wait/timeout counter and optional perf
// counters (CTRL_PERF_EN adds CNT_W, cycle_cnt and instr_cnt).
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
`ifdef CTRL_PERF_EN
    ,
    parameter int CNT_W   = 32
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             v_flag,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic [1:0]       pc_source,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             zero_ext,
    output logic [1:0]       alu_op,
    output logic             illegal_op,
    output logic             mem_timeout,
`ifdef CTRL_PERF_EN
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt,
`endif
    output logic [3:0]       state
);

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_e              r_state;
    state_e              w_next;
    logic [WAIT_W-1:0]   r_wait;
    logic                w_waiting;
    logic                w_timeout;
    logic                w_illegal;
    ctrl_word_t          w_cw;

    assign w_waiting = is_wait_state(r_state) && !mem_ready;
    assign w_timeout = (TIMEOUT != 0) && w_waiting && (r_wait == WAIT_W'(TIMEOUT));
    assign w_illegal = (r_state == S_DECODE) && !is_legal_op(opcode);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (mem_ready)      w_next = S_DECODE;
                else if (w_timeout) w_next = S_FETCH;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_BRNV:      w_next = S_BRNV;
                    OP_ORI:       w_next = S_ORIEX;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready)      w_next = S_MEMWB;
                else if (w_timeout) w_next = S_FETCH;
            end
            // a timed-out store simply leaves; the write is never retried
            S_MEMWR: begin
                if (mem_ready || w_timeout) w_next = S_FETCH;
            end
            S_EXEC:  w_next = S_RWB;
            S_ORIEX: w_next = S_ORIWB;
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            if (w_waiting && !w_timeout) r_wait <= r_wait + WAIT_W'(1);
            else                         r_wait <= '0;
        end
    end

    ctrl_output_decode u_decode (
        .i_state     (r_state),
        .i_zero      (zero),
        .i_v_flag    (v_flag),
        .i_mem_ready (mem_ready),
        .o_cw        (w_cw)
    );

    // Gating with rst_n keeps every enable low for the whole reset window,
    // including the asynchronous part before the next clock edge.
    assign pc_en       = rst_n & w_cw.pc_en;
    assign pc_source   = rst_n ? w_cw.pc_source : 2'b00;
    assign iord        = rst_n & w_cw.iord;
    assign mem_read    = rst_n & w_cw.mem_read;
    assign mem_write   = rst_n & w_cw.mem_write;
    assign ir_write    = rst_n & w_cw.ir_write;
    assign reg_dst     = rst_n & w_cw.reg_dst;
    assign reg_write   = rst_n & w_cw.reg_write;
    assign mem_to_reg  = rst_n & w_cw.mem_to_reg;
    assign alu_src_a   = rst_n & w_cw.alu_src_a;
    assign alu_src_b   = rst_n ? w_cw.alu_src_b : 2'b00;
    assign zero_ext    = rst_n & w_cw.zero_ext;
    assign alu_op      = rst_n ? w_cw.alu_op : 2'b00;
    assign illegal_op  = rst_n & w_illegal;
    assign mem_timeout = rst_n & w_timeout;
    assign state       = rst_n ? r_state : 4'd0;

`ifdef CTRL_PERF_EN
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            if (r_state == S_FETCH && mem_ready) r_instr_cnt <= r_instr_cnt + CNT_W'(1);
        end
    end

    assign cycle_cnt = r_cycle_cnt;
    assign instr_cnt = r_instr_cnt;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (TIMEOUT=4): every output is checked each cycle
// against hand-written per-state control words.
module tb_multicycle_control;

    typedef struct packed {
        logic       pc_en;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       zero_ext;
        logic [1:0] alu_op;
        logic       illegal_op;
        logic       mem_timeout;
        logic [3:0] state;
    } obs_t;

    localparam obs_t E_RST    = '0;
    localparam obs_t E_FETCH  = '{mem_read:1'b1, alu_src_b:2'b01, state:4'd0, default:'0};
    localparam obs_t E_DECODE = '{alu_src_b:2'b11, state:4'd1, default:'0};
    localparam obs_t E_MEMADR = '{alu_src_a:1'b1, alu_src_b:2'b10, state:4'd2, default:'0};
    localparam obs_t E_MEMRD  = '{iord:1'b1, mem_read:1'b1, state:4'd3, default:'0};
    localparam obs_t E_MEMWB  = '{mem_to_reg:1'b1, reg_write:1'b1, state:4'd4, default:'0};
    localparam obs_t E_MEMWR  = '{iord:1'b1, mem_write:1'b1, state:4'd5, default:'0};
    localparam obs_t E_EXEC   = '{alu_src_a:1'b1, alu_op:2'b10, state:4'd6, default:'0};
    localparam obs_t E_RWB    = '{reg_dst:1'b1, reg_write:1'b1, state:4'd7, default:'0};
    localparam obs_t E_BEQ    = '{alu_src_a:1'b1, alu_op:2'b01, pc_source:2'b01, state:4'd8, default:'0};
    localparam obs_t E_BRNV   = '{alu_src_a:1'b1, alu_op:2'b01, pc_source:2'b01, state:4'd9, default:'0};
    localparam obs_t E_ORIEX  = '{alu_src_a:1'b1, alu_src_b:2'b10, zero_ext:1'b1, alu_op:2'b11, state:4'd10, default:'0};
    localparam obs_t E_ORIWB  = '{reg_write:1'b1, state:4'd11, default:'0};

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       v_flag = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, reg_write;
    logic       mem_to_reg, alu_src_a, zero_ext, illegal_op, mem_timeout;
    logic [1:0] pc_source, alu_src_b, alu_op;
    logic [3:0] state;
`ifdef CTRL_PERF_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif
    obs_t       obs;
    int         n_assert = 0;
    int         n_fail = 0;

    multicycle_control #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .zero        (zero),
        .v_flag      (v_flag),
        .mem_ready   (mem_ready),
        .pc_en       (pc_en),
        .pc_source   (pc_source),
        .iord        (iord),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_dst     (reg_dst),
        .reg_write   (reg_write),
        .mem_to_reg  (mem_to_reg),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .zero_ext    (zero_ext),
        .alu_op      (alu_op),
        .illegal_op  (illegal_op),
        .mem_timeout (mem_timeout),
`ifdef CTRL_PERF_EN
        .cycle_cnt   (cycle_cnt),
        .instr_cnt   (instr_cnt),
`endif
        .state       (state)
    );

    assign obs = {pc_en, pc_source, iord, mem_read, mem_write, ir_write, reg_dst, reg_write,
                  mem_to_reg, alu_src_a, alu_src_b, zero_ext, alu_op, illegal_op, mem_timeout, state};

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input obs_t exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs are set at a falling edge; check just after, then advance one cycle.
    task automatic cyc(input string tag, input obs_t exp);
        #1;
        chk(tag, exp);
        @(negedge clk);
    endtask

    task automatic go(input logic [5:0] op, input string tag);
        obs_t e;
        $display("txn %s opcode=%b", tag, op);
        opcode    = op;
        mem_ready = 1'b1;
        e = E_FETCH;
        e.pc_en    = 1'b1;
        e.ir_write = 1'b1;
        cyc(tag, e);
    endtask

    task automatic branch(input logic [5:0] op, input logic z, input logic v,
                          input logic exp_pc_en, input string tag);
        obs_t e;
        go(op, tag);
        cyc({tag, "_decode"}, E_DECODE);
        zero   = z;
        v_flag = v;
        e = (op == 6'b000100) ? E_BEQ : E_BRNV;
        e.pc_en = exp_pc_en;
        cyc(tag, e);
        zero   = 1'b0;
        v_flag = 1'b0;
    endtask

    initial begin
        obs_t e;
        rst_n = 1'b0;
        @(negedge clk);
        cyc("reset_idle", E_RST);
        rst_n = 1'b1;

        // lw with memory always ready
        go(6'b100011, "lw_fetch");
        cyc("lw_decode", E_DECODE);
        cyc("lw_memadr", E_MEMADR);
        cyc("lw_memrd", E_MEMRD);
        cyc("lw_memwb", E_MEMWB);

        // R-type fetch stalled three cycles
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("fetch_stall", E_FETCH);
        go(6'b000000, "r_fetch");
        cyc("r_decode", E_DECODE);
        cyc("r_exec", E_EXEC);
        cyc("r_rwb", E_RWB);

        branch(6'b000100, 1'b1, 1'b0, 1'b1, "beq_taken");
        branch(6'b000100, 1'b0, 1'b0, 1'b0, "beq_not_taken");
        branch(6'b010101, 1'b0, 1'b1, 1'b0, "brnv_ovf");
        branch(6'b010101, 1'b0, 1'b0, 1'b1, "brnv_taken");

        go(6'b001101, "ori_fetch");
        cyc("ori_decode", E_DECODE);
        cyc("ori_ex", E_ORIEX);
        cyc("ori_wb", E_ORIWB);

        go(6'b111111, "illegal_fetch");
        e = E_DECODE;
        e.illegal_op = 1'b1;
        cyc("illegal_decode", e);
        mem_ready = 1'b0;
        cyc("illegal_next", E_FETCH);

        // sw timeout: four quiet wait cycles, pulse on the fifth
        go(6'b101011, "sw_to_fetch");
        cyc("sw_to_decode", E_DECODE);
        cyc("sw_to_memadr", E_MEMADR);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) cyc("sw_to_wait", E_MEMWR);
        e = E_MEMWR;
        e.mem_timeout = 1'b1;
        cyc("sw_timeout", e);
        cyc("sw_to_next", E_FETCH);

        // mem_ready wins over the timeout in the same cycle
        go(6'b101011, "sw_prio_fetch");
        cyc("sw_prio_decode", E_DECODE);
        cyc("sw_prio_memadr", E_MEMADR);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) cyc("sw_prio_wait", E_MEMWR);
        mem_ready = 1'b1;
        cyc("sw_prio_done", E_MEMWR);
        mem_ready = 1'b0;
        cyc("sw_prio_next", E_FETCH);

        // asynchronous reset during a pending store
        go(6'b101011, "sw_rst_fetch");
        cyc("sw_rst_decode", E_DECODE);
        cyc("sw_rst_memadr", E_MEMADR);
        mem_ready = 1'b0;
        #1;
        chk("sw_rst_memwr", E_MEMWR);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", E_RST);
        @(negedge clk);
        cyc("reset_held", E_RST);
        rst_n = 1'b1;
        go(6'b000000, "post_rst_fetch");
        cyc("post_rst_decode", E_DECODE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
